sd_img_responder: RTL and testbench

- Synthesizable stand-in for the HPS side of the core's virtual-disk block interface (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Serves 512-byte sectors of a disk image held in DDR behind an Avalon-MM 64-bit burst master.
- Sits between the SCSI image logic in ss_core and a DDRAM port, so the core boots from an image without the HPS (standalone boards, simulation).
- One instance per virtual drive.

---
 rtl/sd_resp_pkg.sv | 23 ++
 rtl/sd_resp_secbuf.sv | 27 ++
 rtl/sd_img_responder.sv | 207 ++++++++++++++++++++
 tb/tb_sd_img_responder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_resp_pkg.sv
// rtl/sd_resp_pkg.sv - shared types and constants for the virtual-disk sector responder
package sd_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_FILL,
        RD_OUT,
        WR_IN,
        WR_MEM,
        DONE
    } state_t;

    localparam int SECT_WORDS = 256;
    localparam int SECT_BEATS = 64;
    localparam logic [7:0] BURST_LEN = 8'd64;

    // Big-endian image layout swaps the two bytes of every 16-bit sector word.
    function automatic logic [15:0] bswap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/sd_resp_secbuf.sv
// rtl/sd_resp_secbuf.sv - 64x64 sector buffer, one write port with 16-bit lane enables, registered read
module sd_resp_secbuf (
    input  logic        clk,
    input  logic [3:0]  lane_we,
    input  logic [5:0]  waddr,
    input  logic [63:0] wdata,
    input  logic [5:0]  raddr,
    output logic [63:0] rdata
);

    logic [63:0] mem [0:63];

    // Lane-granular write so the core-side path can pack one word at a time.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (lane_we[j]) begin
                mem[waddr][16*j +: 16] <= wdata[16*j +: 16];
            end
        end
    end

    // Read is re-issued every cycle, so rdata always reflects the current raddr one cycle later.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sd_img_responder.sv
// rtl/sd_img_responder.sv - serves 512-byte virtual-disk sectors from DDR over Avalon-MM; SD_RESP_BSWAP_EN byte-swaps sector words
module sd_img_responder #(
    parameter logic [28:0] BASE_ADDR   = 29'h0,
    parameter logic [31:0] IMG_SECTORS = 32'h0010_0000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [7:0]  sd_buff_addr,
    output logic [15:0] sd_buff_dout,
    output logic        sd_buff_wr,
    input  logic [15:0] sd_buff_din,
    output logic [28:0] mem_address,
    output logic [7:0]  mem_burstcount,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    output logic [7:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [63:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic        busy,
    output logic        err
);

    import sd_resp_pkg::*;

    state_t      state, state_next;
    logic [8:0]  cnt, cnt_next;
    logic [22:0] lba_q;
    logic        is_wr_q;
    logic        oor_q;
    logic        err_q;
    logic        cap_valid_q;
    logic [7:0]  cap_idx_q;
    logic        req_oor;
    logic        mem_cmd;
    logic [7:0]  next_word;
    logic [5:0]  buf_raddr;
    logic [63:0] buf_rdata;
    logic [3:0]  buf_lane_we;
    logic [5:0]  buf_waddr;
    logic [63:0] buf_wdata;

`ifdef SD_RESP_BSWAP_EN
    function automatic logic [15:0] word_xf(input logic [15:0] w);
        return bswap16(w);
    endfunction
`else
    function automatic logic [15:0] word_xf(input logic [15:0] w);
        return w;
    endfunction
`endif

    assign req_oor   = (sd_lba >= IMG_SECTORS);
    assign next_word = cnt[7:0] + 8'd1;

    sd_resp_secbuf u_secbuf (
        .clk     (clk_sys),
        .lane_we (buf_lane_we),
        .waddr   (buf_waddr),
        .wdata   (buf_wdata),
        .raddr   (buf_raddr),
        .rdata   (buf_rdata)
    );

    // State and the shared beat/word counter.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, counter advance and all state-decoded outputs; counter restarts on every state change.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        sd_ack       = 1'b0;
        busy         = 1'b1;
        sd_buff_wr   = 1'b0;
        sd_buff_addr = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        buf_raddr    = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (sd_rd) begin
                    state_next = req_oor ? RD_OUT : RD_CMD;
                end else if (sd_wr) begin
                    state_next = WR_IN;
                end
            end
            RD_CMD: begin
                sd_ack   = 1'b1;
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = RD_FILL;
                end
            end
            RD_FILL: begin
                sd_ack = 1'b1;
                if (mem_readdatavalid) begin
                    cnt_next = cnt + 9'd1;
                    if (cnt == 9'(SECT_BEATS - 1)) begin
                        state_next = RD_OUT;
                    end
                end
            end
            RD_OUT: begin
                sd_ack       = 1'b1;
                sd_buff_wr   = 1'b1;
                sd_buff_addr = cnt[7:0];
                buf_raddr    = next_word[7:2];
                cnt_next     = cnt + 9'd1;
                if (cnt == 9'(SECT_WORDS - 1)) begin
                    state_next = DONE;
                end
            end
            WR_IN: begin
                sd_ack       = 1'b1;
                sd_buff_addr = cnt[7:0];
                cnt_next     = cnt + 9'd1;
                if (cnt == 9'(SECT_WORDS)) begin
                    state_next = oor_q ? DONE : WR_MEM;
                end
            end
            WR_MEM: begin
                sd_ack    = 1'b1;
                mem_write = 1'b1;
                buf_raddr = mem_waitrequest ? cnt[5:0] : cnt[5:0] + 6'd1;
                if (!mem_waitrequest) begin
                    cnt_next = cnt + 9'd1;
                    if (cnt == 9'(SECT_BEATS - 1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (!(is_wr_q ? sd_wr : sd_rd)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_next != state) begin
            cnt_next = '0;
        end
    end

    // Sector buffer writes: whole beats from DDR, or single lanes from the core one cycle after the address.
    always_comb begin
        buf_lane_we = '0;
        buf_waddr   = '0;
        buf_wdata   = '0;
        if (state == RD_FILL && mem_readdatavalid) begin
            buf_lane_we = 4'hF;
            buf_waddr   = cnt[5:0];
            buf_wdata   = {word_xf(mem_readdata[63:48]), word_xf(mem_readdata[47:32]),
                           word_xf(mem_readdata[31:16]), word_xf(mem_readdata[15:0])};
        end else if (cap_valid_q && !oor_q) begin
            buf_lane_we = 4'b0001 << cap_idx_q[1:0];
            buf_waddr   = cap_idx_q[7:2];
            buf_wdata   = {4{word_xf(sd_buff_din)}};
        end
    end

    // Request latch, error pulse and the one-cycle delayed capture of the core RAM address.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lba_q       <= '0;
            is_wr_q     <= 1'b0;
            oor_q       <= 1'b0;
            err_q       <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            err_q       <= 1'b0;
            cap_valid_q <= (state == WR_IN) && !cnt[8];
            cap_idx_q   <= cnt[7:0];
            if (state == IDLE && (sd_rd || sd_wr)) begin
                lba_q   <= sd_lba[22:0];
                is_wr_q <= !sd_rd;
                oor_q   <= req_oor;
                err_q   <= req_oor;
            end
        end
    end

    assign mem_cmd        = mem_read | mem_write;
    assign mem_address    = mem_cmd ? BASE_ADDR + {lba_q, 6'b0} : '0;
    assign mem_burstcount = mem_cmd ? BURST_LEN : '0;
    assign mem_byteenable = mem_cmd ? 8'hFF : '0;
    assign mem_writedata  = mem_write ? buf_rdata : '0;
    assign sd_buff_dout   = (sd_buff_wr && !oor_q) ? buf_rdata[{cnt[1:0], 4'b0000} +: 16] : '0;
    assign err            = err_q;

endmodule

// File: tb/tb_sd_img_responder.sv
// tb/tb_sd_img_responder.sv - scoreboard bench for sd_img_responder with DDR and core RAM models
module tb_sd_img_responder;

    localparam logic [28:0] BASE = 29'h0000_1000;
    localparam logic [31:0] NSEC = 32'd16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic        sd_rd = 1'b0;
    logic        sd_wr = 1'b0;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic [28:0] mem_address;
    logic [7:0]  mem_burstcount;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [7:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b0;
    logic [63:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;
    logic        busy;
    logic        err;

    sd_img_responder #(.BASE_ADDR(BASE), .IMG_SECTORS(NSEC)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_address(mem_address),
        .mem_burstcount(mem_burstcount), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .busy(busy), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed { logic [7:0] addr; logic [15:0] data; } rd_exp_t;
    typedef struct packed { logic [28:0] addr; logic [63:0] data; } wr_exp_t;

    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          wr_beat = 0;
    logic        stall_en = 1'b0;
    logic [63:0] ddr [logic [28:0]];
    logic [15:0] core_ram [256];
    rd_exp_t     exp_rd [$];
    wr_exp_t     exp_wr [$];
    logic [28:0] exp_raddr [$];
    rd_exp_t     mon_r;
    wr_exp_t     mon_w;
    logic [28:0] mon_a;

    function automatic logic [15:0] xf(input logic [15:0] w);
`ifdef SD_RESP_BSWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    // Unwritten DDR word at offset k from BASE holds k in every lane.
    function automatic logic [63:0] ddr_word(input logic [28:0] a);
        logic [15:0] k;
        k = 16'(a - BASE);
        if (ddr.exists(a)) return ddr[a];
        return {4{k}};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0: return sd_ack;
            1: return busy;
            default: return sd_buff_wr;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [63:0] val);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, value %h", name, val);
    endtask

    task automatic wait_for(input string name, input int sel, input logic lvl, input int lim);
        int t;
        t = 0;
        while (sig(sel) !== lvl && t < lim) begin
            @(posedge clk_sys);
            #1;
            t++;
        end
        chk(name, 64'(sig(sel)), 64'(lvl));
    endtask

    task automatic push_rd(input logic [31:0] lba);
        logic [28:0] a0;
        logic [63:0] b;
        rd_exp_t     e;
        a0 = 29'(BASE + lba * 64);
        if (lba < NSEC) exp_raddr.push_back(a0);
        for (int n = 0; n < 256; n++) begin
            b = ddr_word(a0 + 29'(n / 4)) >> (16 * (n % 4));
            e.addr = 8'(n);
            e.data = (lba < NSEC) ? xf(b[15:0]) : 16'h0000;
            exp_rd.push_back(e);
        end
    endtask

    task automatic push_wr(input logic [31:0] lba, input bit pat);
        wr_exp_t e;
        for (int n = 0; n < 256; n++) begin
            core_ram[n] = pat ? (16'(n) ^ 16'hA5A5) : 16'($urandom);
        end
        if (lba < NSEC) begin
            for (int k = 0; k < 64; k++) begin
                e.addr = 29'(BASE + lba * 64);
                e.data = {xf(core_ram[4*k+3]), xf(core_ram[4*k+2]), xf(core_ram[4*k+1]), xf(core_ram[4*k])};
                exp_wr.push_back(e);
            end
        end
    endtask

    task automatic check_drained();
        chk("read words drained", 64'(exp_rd.size()), 64'd0);
        chk("write beats drained", 64'(exp_wr.size()), 64'd0);
        chk("read commands drained", 64'(exp_raddr.size()), 64'd0);
    endtask

    task automatic run_req(input bit is_wr, input logic [31:0] lba, input bit hold, input bit pat);
        int e0;
        e0 = err_seen;
        if (is_wr) push_wr(lba, pat);
        else push_rd(lba);
        @(posedge clk_sys);
        #1;
        sd_lba = lba;
        sd_rd  = !is_wr;
        sd_wr  = is_wr;
        wait_for("ack rise", 0, 1'b1, 300);
        if (hold) begin
            wait_for("ack fall", 0, 1'b0, 3000);
            repeat (5) begin
                @(posedge clk_sys);
                #1;
            end
            chk("held request keeps busy", 64'(busy), 64'd1);
            chk("held request no reack", 64'(sd_ack), 64'd0);
        end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        wait_for("busy fall", 1, 1'b0, 3000);
        @(posedge clk_sys);
        #1;
        check_drained();
        chk("err pulse count", 64'(err_seen - e0), (lba >= NSEC) ? 64'd1 : 64'd0);
    endtask

    // Core RAM: one cycle of read latency from sd_buff_addr to sd_buff_din.
    always @(posedge clk_sys) sd_buff_din <= core_ram[sd_buff_addr];

    // Random Avalon stall, applied just after the edge.
    always @(posedge clk_sys) begin
        #1;
        mem_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // DDR read responder: fixed latency, then 64 beats with optional gaps.
    initial begin
        logic [28:0] a;
        int k;
        forever begin
            @(posedge clk_sys);
            if (reset_n && mem_read && !mem_waitrequest) begin
                a = mem_address;
                repeat (3) @(posedge clk_sys);
                k = 0;
                while (k < 64) begin
                    #1;
                    if (stall_en && $urandom_range(0, 3) == 0) begin
                        mem_readdatavalid = 1'b0;
                    end else begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata = ddr_word(a + 29'(k));
                        k++;
                    end
                    @(posedge clk_sys);
                end
                #1 mem_readdatavalid = 1'b0;
            end
        end
    end

    // Monitor: pops and compares every core strobe, DDR command and write beat.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (err) err_seen++;
            if (sd_buff_wr) begin
                if (exp_rd.size() == 0) begin
                    note_fail("extra strobe", 64'(sd_buff_addr));
                end else begin
                    mon_r = exp_rd.pop_front();
                    chk("strobe addr", 64'(sd_buff_addr), 64'(mon_r.addr));
                    chk("strobe data", 64'(sd_buff_dout), 64'(mon_r.data));
                    chk("ack during strobe", 64'(sd_ack), 64'd1);
                end
            end
            if (mem_read && !mem_waitrequest) begin
                if (exp_raddr.size() == 0) begin
                    note_fail("extra mem_read", 64'(mem_address));
                end else begin
                    mon_a = exp_raddr.pop_front();
                    chk("read address", 64'(mem_address), 64'(mon_a));
                    chk("read burstcount", 64'(mem_burstcount), 64'd64);
                end
            end
            if (mem_write && !mem_waitrequest) begin
                if (exp_wr.size() == 0) begin
                    note_fail("extra write beat", mem_writedata);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("write address", 64'(mem_address), 64'(mon_w.addr));
                    chk("write data", mem_writedata, mon_w.data);
                    chk("write burst/be", {48'd0, mem_burstcount, mem_byteenable}, 64'h40FF);
                end
                ddr[mem_address + 29'(wr_beat)] = mem_writedata;
                wr_beat = (wr_beat + 1) % 64;
            end
        end else begin
            wr_beat = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset control outs", {58'd0, sd_ack, busy, sd_buff_wr, mem_read, mem_write, err}, 64'd0);
        chk("reset buff addr/dout", {40'd0, sd_buff_addr, sd_buff_dout}, 64'd0);
        chk("reset mem addr/bc/be", {19'd0, mem_address, mem_burstcount, mem_byteenable}, 64'd0);
        chk("reset writedata", mem_writedata, 64'd0);
        reset_n = 1'b1;

        run_req(1'b0, 32'd0, 1'b0, 1'b0);
        run_req(1'b1, 32'd5, 1'b0, 1'b1);
`ifdef SD_RESP_BSWAP_EN
        chk("write lba5 beat0", ddr_word(BASE + 29'd320), 64'hA6A5A7A5A4A5A5A5);
`else
        chk("write lba5 beat0", ddr_word(BASE + 29'd320), 64'hA5A6A5A7A5A4A5A5);
`endif
        run_req(1'b0, NSEC, 1'b0, 1'b0);
        run_req(1'b1, NSEC + 32'd1, 1'b0, 1'b0);

        stall_en = 1'b1;
        run_req(1'b1, 32'd5, 1'b0, 1'b1);
        run_req(1'b0, 32'd5, 1'b0, 1'b0);
        stall_en = 1'b0;

        run_req(1'b0, 32'd1, 1'b1, 1'b0);

        // Simultaneous read and write: read first, write once sd_rd drops.
        push_rd(32'd3);
        push_wr(32'd3, 1'b0);
        @(posedge clk_sys);
        #1;
        sd_lba = 32'd3;
        sd_rd  = 1'b1;
        sd_wr  = 1'b1;
        wait_for("both: ack rise", 0, 1'b1, 300);
        sd_rd = 1'b0;
        wait_for("both: read done", 1, 1'b0, 3000);
        chk("both: read first", 64'(exp_rd.size()), 64'd0);
        chk("both: write pending", 64'(exp_wr.size()), 64'd64);
        wait_for("both: write ack", 0, 1'b1, 300);
        sd_wr = 1'b0;
        wait_for("both: write done", 1, 1'b0, 3000);
        @(posedge clk_sys);
        #1;
        check_drained();

        // Reset in the middle of streaming out a sector.
        push_rd(32'd1);
        @(posedge clk_sys);
        #1;
        sd_lba = 32'd1;
        sd_rd  = 1'b1;
        wait_for("rst: ack rise", 0, 1'b1, 300);
        sd_rd = 1'b0;
        wait_for("rst: strobes start", 2, 1'b1, 3000);
        repeat (20) begin
            @(posedge clk_sys);
            #1;
        end
        @(negedge clk_sys);
        #1 reset_n = 1'b0;
        #1;
        chk("rst: ack low", 64'(sd_ack), 64'd0);
        chk("rst: busy low", 64'(busy), 64'd0);
        chk("rst: strobe low", 64'(sd_buff_wr), 64'd0);
        exp_rd.delete();
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        run_req(1'b0, 32'd2, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            stall_en = 1'($urandom_range(0, 1));
            run_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 18)), 1'b0, 1'b0);
        end
        stall_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
